// File: rtl/sol32_data_port.sv
// sol32 core data-port responder: zero-latency word RAM plus a compare timer/status MMIO block.
// Optional: define SOL32_DMEM_FAULT_IRQ_EN to let CONTROL[3] route misalignment faults onto Interrupt.
module sol32_data_port #(
   parameter int unsigned AddrBits = 10,
   parameter logic [31:0] MmioBase = 32'hFFFF_FF00
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        ReadEnable,
   input  logic        WriteEnable,
   input  logic [1:0]  DataWidth,
   input  logic [31:0] MemoryAddress,
   input  logic [31:0] DataOut,
   output logic [31:0] DataIn,
   output logic        Interrupt
);

   localparam int unsigned Depth = 2 ** AddrBits;
`ifdef SOL32_DMEM_FAULT_IRQ_EN
   localparam logic [3:0] CtlMask = 4'hF;
`else
   localparam logic [3:0] CtlMask = 4'h7;
`endif

   localparam logic [7:0] OffCount   = 8'h00;
   localparam logic [7:0] OffCompare = 8'h04;
   localparam logic [7:0] OffControl = 8'h08;
   localparam logic [7:0] OffStatus  = 8'h0C;

   logic [31:0] mem [Depth];

   logic [31:0] timer_count, timer_compare;
   logic [3:0]  control;
   logic [1:0]  status;

   logic                is_mmio, misalign, fault, ram_we, mmio_we;
   logic [7:0]          offset;
   logic [AddrBits-1:0] word_idx;
   logic [31:0]         rd_word, lane_shift, mmio_rdata, wdata;
   logic [3:0]          be;

   logic [31:0] cnt_nxt, cmp_nxt;
   logic [3:0]  ctl_nxt;
   logic [1:0]  st_nxt, st_set, st_clr;
   logic        irq_nxt, match;

   assign is_mmio  = (MemoryAddress[31:8] == MmioBase[31:8]);
   assign offset   = MemoryAddress[7:0];
   assign word_idx = MemoryAddress[AddrBits+1:2];

   always_comb begin
      case (DataWidth)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = MemoryAddress[0];
         2'b10:   misalign = (MemoryAddress[1:0] != 2'b00);
         default: misalign = 1'b1;
      endcase
      if (is_mmio && DataWidth != 2'b10) misalign = 1'b1;
   end

   assign fault   = (ReadEnable | WriteEnable) & misalign;
   // A write racing an asserted reset must not land in the RAM either.
   assign ram_we  = WriteEnable & ~misalign & ~is_mmio & ~Reset;
   assign mmio_we = WriteEnable & ~misalign & is_mmio;

   // Read path
   assign rd_word    = mem[word_idx];
   assign lane_shift = rd_word >> {MemoryAddress[1:0], 3'b000};

   always_comb begin
      case (offset)
         OffCount:   mmio_rdata = timer_count;
         OffCompare: mmio_rdata = timer_compare;
         OffControl: mmio_rdata = {28'b0, control};
         OffStatus:  mmio_rdata = {30'b0, status};
         default:    mmio_rdata = '0;
      endcase
   end

   always_comb begin
      DataIn = '0;
      if (ReadEnable && !WriteEnable && !misalign) begin
         if (is_mmio) begin
            DataIn = mmio_rdata;
         end else begin
            case (DataWidth)
               2'b00:   DataIn = {24'b0, lane_shift[7:0]};
               2'b01:   DataIn = {16'b0, lane_shift[15:0]};
               default: DataIn = rd_word;
            endcase
         end
      end
   end

   // Write path: replicate the payload across lanes and pick lanes with byte enables
   always_comb begin
      case (DataWidth)
         2'b00: begin
            be    = 4'b0001 << MemoryAddress[1:0];
            wdata = {4{DataOut[7:0]}};
         end
         2'b01: begin
            be    = MemoryAddress[1] ? 4'b1100 : 4'b0011;
            wdata = {2{DataOut[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = DataOut;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (ram_we) begin
         if (be[0]) mem[word_idx][7:0]   <= wdata[7:0];
         if (be[1]) mem[word_idx][15:8]  <= wdata[15:8];
         if (be[2]) mem[word_idx][23:16] <= wdata[23:16];
         if (be[3]) mem[word_idx][31:24] <= wdata[31:24];
      end
   end

   // Timer and register next-state
   assign match = control[0] && (timer_count == timer_compare);

   always_comb begin
      cnt_nxt = timer_count;
      if (control[0]) begin
         cnt_nxt = (match && control[1]) ? '0 : timer_count + 32'd1;
      end
      if (mmio_we && offset == OffCount) cnt_nxt = DataOut;

      cmp_nxt = (mmio_we && offset == OffCompare) ? DataOut : timer_compare;
      ctl_nxt = (mmio_we && offset == OffControl) ? (DataOut[3:0] & CtlMask) : control;

      st_set = {fault, match};
      st_clr = (mmio_we && offset == OffStatus) ? DataOut[1:0] : 2'b00;
      st_nxt = (status & ~st_clr) | st_set;

`ifdef SOL32_DMEM_FAULT_IRQ_EN
      irq_nxt = (st_nxt[0] & ctl_nxt[2]) | (st_nxt[1] & ctl_nxt[3]);
`else
      irq_nxt = st_nxt[0] & ctl_nxt[2];
`endif
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         timer_count   <= '0;
         timer_compare <= '0;
         control       <= '0;
         status        <= '0;
         Interrupt     <= 1'b0;
      end else begin
         timer_count   <= cnt_nxt;
         timer_compare <= cmp_nxt;
         control       <= ctl_nxt;
         status        <= st_nxt;
         Interrupt     <= irq_nxt;
      end
   end

endmodule

// File: tb/tb_sol32_data_port.sv
// Self-checking bench for sol32_data_port: directed scenarios then random traffic against a byte-level model.
module tb_sol32_data_port;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        ReadEnable, WriteEnable;
   logic [1:0]  DataWidth;
   logic [31:0] MemoryAddress, DataOut;
   logic [31:0] DataIn;
   logic        Interrupt;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] MB = 32'hFFFF_FF00;
`ifdef SOL32_DMEM_FAULT_IRQ_EN
   localparam logic [3:0] CMASK = 4'hF;
`else
   localparam logic [3:0] CMASK = 4'h7;
`endif

   sol32_data_port #(.AddrBits(10), .MmioBase(MB)) dut (
      .Clock(Clock), .Reset(Reset), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
      .DataWidth(DataWidth), .MemoryAddress(MemoryAddress), .DataOut(DataOut),
      .DataIn(DataIn), .Interrupt(Interrupt)
   );

   always #5 Clock = ~Clock;

   // Reference model: byte-addressed memory image plus the four MMIO registers
   logic [7:0]  mem_m [4096];
   logic [31:0] m_cnt, m_cmp;
   logic [3:0]  m_ctl;
   logic [1:0]  m_st;

   function automatic logic is_mmio(input logic [31:0] a);
      return a[31:8] == MB[31:8];
   endfunction

   function automatic logic misal(input logic [1:0] w, input logic [31:0] a);
      if (is_mmio(a) && w != 2'd2) return 1'b1;
      if (w == 2'd3) return 1'b1;
      if (w == 2'd1) return a[0];
      if (w == 2'd2) return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_rd(input logic re, input logic we, input logic [1:0] w,
                                          input logic [31:0] a);
      int unsigned b;
      if (!re || we || misal(w, a)) return 32'd0;
      if (is_mmio(a)) begin
         case (a[7:0])
            8'h00:   return m_cnt;
            8'h04:   return m_cmp;
            8'h08:   return {28'd0, m_ctl};
            8'h0C:   return {30'd0, m_st};
            default: return 32'd0;
         endcase
      end
      b = a[11:0];
      case (w)
         2'd0:    return {24'd0, mem_m[b]};
         2'd1:    return {16'd0, mem_m[b+1], mem_m[b]};
         default: return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
      endcase
   endfunction

   function automatic logic exp_irq();
`ifdef SOL32_DMEM_FAULT_IRQ_EN
      return (m_st[0] & m_ctl[2]) | (m_st[1] & m_ctl[3]);
`else
      return m_st[0] & m_ctl[2];
`endif
   endfunction

   task automatic model_reset();
      m_cnt = 32'd0;
      m_cmp = 32'd0;
      m_ctl = 4'd0;
      m_st  = 2'd0;
   endtask

   task automatic model_edge(input logic re, input logic we, input logic [1:0] w,
                             input logic [31:0] a, input logic [31:0] d);
      logic        f;
      logic [1:0]  set, clr;
      logic [31:0] nc;
      int unsigned b;
      f   = (re | we) && misal(w, a);
      set = {f, 1'b0};
      clr = 2'b00;
      nc  = m_cnt;
      if (m_ctl[0]) begin
         if (m_cnt == m_cmp) begin
            set[0] = 1'b1;
            nc = m_ctl[1] ? 32'd0 : m_cnt + 32'd1;
         end else begin
            nc = m_cnt + 32'd1;
         end
      end
      if (we && !f) begin
         if (is_mmio(a)) begin
            case (a[7:0])
               8'h00: nc = d;
               8'h04: m_cmp = d;
               8'h08: m_ctl = d[3:0] & CMASK;
               8'h0C: clr = d[1:0];
               default: ;
            endcase
         end else begin
            b = a[11:0];
            mem_m[b] = d[7:0];
            if (w != 2'd0) mem_m[b+1] = d[15:8];
            if (w == 2'd2) begin
               mem_m[b+2] = d[23:16];
               mem_m[b+3] = d[31:24];
            end
         end
      end
      m_cnt = nc;
      m_st  = (m_st & ~clr) | set;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, check combinational read data, clock it, check Interrupt
   task automatic step(input string tag, input logic re, input logic we, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d);
      ReadEnable = re; WriteEnable = we; DataWidth = w; MemoryAddress = a; DataOut = d;
      #1;
      chk({tag, "_rd"}, DataIn, exp_rd(re, we, w, a));
      @(posedge Clock);
      model_edge(re, we, w, a, d);
      #1;
      chk({tag, "_irq"}, {31'd0, Interrupt}, {31'd0, exp_irq()});
   endtask

   task automatic wr(input string tag, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
      step(tag, 1'b0, 1'b1, w, a, d);
   endtask

   task automatic rd(input string tag, input logic [1:0] w, input logic [31:0] a);
      step(tag, 1'b1, 1'b0, w, a, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] r1, r2, a, d;
      int unsigned k;
      Reset = 1'b1; ReadEnable = 0; WriteEnable = 0; DataWidth = 0; MemoryAddress = 0; DataOut = 0;
      model_reset();
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b0;

      // Reset state of every register
      rd("rst_cnt", 2'd2, MB + 32'h00);
      rd("rst_cmp", 2'd2, MB + 32'h04);
      rd("rst_ctl", 2'd2, MB + 32'h08);
      rd("rst_st",  2'd2, MB + 32'h0C);
      chk("rst_irq_const", {31'd0, Interrupt}, 32'd0);

      for (int i = 0; i < 64; i++) wr("clr", 2'd2, 32'(i * 4), 32'd0);

      // Byte and half reads of a word, byte merge, misaligned half write
      wr("w_word", 2'd2, 32'h10, 32'hDEADBEEF);
      rd("r_byte11", 2'd0, 32'h11);
      rd("r_half12", 2'd1, 32'h12);
      wr("w_byte13", 2'd0, 32'h13, 32'h0000005A);
      rd("r_word10", 2'd2, 32'h10);
      wr("w_half11_bad", 2'd1, 32'h11, 32'h00001234);
      rd("r_word10b", 2'd2, 32'h10);
      rd("r_st_fault", 2'd2, MB + 32'h0C);
      step("rw_both", 1'b1, 1'b1, 2'd2, 32'h10, 32'h11111111);
      rd("r_word10c", 2'd2, 32'h10);
      rd("r_rsvd_w", 2'd3, 32'h10);
      rd("r_mmio_byte", 2'd0, MB + 32'h00);
      rd("r_mmio_other", 2'd2, MB + 32'h40);
      rd("r_alias", 2'd2, 32'h1234_5010);
      wr("st_w1c", 2'd2, MB + 32'h0C, 32'h3);

      // Compare timer with auto-clear and interrupt
      wr("cmp5", 2'd2, MB + 32'h04, 32'd5);
      wr("ctl7", 2'd2, MB + 32'h08, 32'h7);
      for (int i = 0; i < 7; i++) rd("t_cnt", 2'd2, MB + 32'h00);
      rd("t_st", 2'd2, MB + 32'h0C);
      wr("t_w1c", 2'd2, MB + 32'h0C, 32'h1);
      rd("t_st2", 2'd2, MB + 32'h0C);

      // Wraparound, no IRQ while disabled, then enable
      wr("ctl0", 2'd2, MB + 32'h08, 32'h0);
      wr("st_clr", 2'd2, MB + 32'h0C, 32'h3);
      wr("ctl1", 2'd2, MB + 32'h08, 32'h1);
      wr("cntmax", 2'd2, MB + 32'h00, 32'hFFFF_FFFF);
      wr("cmp3", 2'd2, MB + 32'h04, 32'd3);
      for (int i = 0; i < 5; i++) rd("wrap_cnt", 2'd2, MB + 32'h00);
      rd("wrap_st", 2'd2, MB + 32'h0C);
      wr("ctl5", 2'd2, MB + 32'h08, 32'h5);
      chk("irq_en_const", {31'd0, Interrupt}, 32'd1);

      // Set beats W1C on a match edge; COUNT write beats auto-clear
      wr("ctl3", 2'd2, MB + 32'h08, 32'h3);
      wr("st_clr2", 2'd2, MB + 32'h0C, 32'h3);
      wr("cmp12", 2'd2, MB + 32'h04, 32'd12);
      wr("cnt10", 2'd2, MB + 32'h00, 32'd10);
      rd("c_idle", 2'd2, MB + 32'h00);
      wr("w1c_on_match", 2'd2, MB + 32'h0C, 32'h1);
      rd("c_st", 2'd2, MB + 32'h0C);
      wr("st_clr3", 2'd2, MB + 32'h0C, 32'h3);
      wr("cnt12", 2'd2, MB + 32'h00, 32'd12);
      wr("cnt100_on_match", 2'd2, MB + 32'h00, 32'd100);
      rd("c_cnt100", 2'd2, MB + 32'h00);

      // Asynchronous reset mid-count drops a same-edge RAM write
      wr("ctl7b", 2'd2, MB + 32'h08, 32'h7);
      wr("cmp2", 2'd2, MB + 32'h04, 32'd2);
      repeat (4) rd("pre_rst", 2'd2, MB + 32'h00);
      ReadEnable = 0; WriteEnable = 1; DataWidth = 2'd2; MemoryAddress = 32'h20; DataOut = 32'hCAFEF00D;
      #2 Reset = 1'b1;
      model_reset();
      #1 chk("rst_irq_now", {31'd0, Interrupt}, 32'd0);
      @(posedge Clock);
      #1;
      WriteEnable = 0; ReadEnable = 1;
      for (int i = 0; i < 4; i++) begin
         MemoryAddress = MB + 32'(i * 4);
         #1 chk("in_rst_reg", DataIn, exp_rd(1'b1, 1'b0, 2'd2, MemoryAddress));
      end
      @(posedge Clock);
      #1 Reset = 1'b0;
      rd("rst_dropped", 2'd2, 32'h20);

`ifdef SOL32_DMEM_FAULT_IRQ_EN
      wr("ctl8", 2'd2, MB + 32'h08, 32'h8);
      rd("mis_word", 2'd2, 32'h22);
      chk("fault_irq_const", {31'd0, Interrupt}, 32'd1);
      wr("st_clr4", 2'd2, MB + 32'h0C, 32'h3);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         r1 = $urandom();
         r2 = $urandom_range(0, 255);
         d  = $urandom();
         k  = $urandom_range(0, 3);
         if (k == 0) begin
            case ($urandom_range(0, 5))
               0: a = MB + 32'h00;
               1: a = MB + 32'h04;
               2: a = MB + 32'h08;
               3: a = MB + 32'h0C;
               4: a = MB + 32'h10;
               default: a = {MB[31:8], r2[7:0]};
            endcase
            if (a[7:0] == 8'h04) d = d & 32'h1F;
         end else begin
            a = {r1[31:12], 4'h0, r2[7:0]};
         end
         step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), a, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
